// File: rtl/seg_display_ctrl.sv
// Eight-digit hex display controller: debounced mode/address buttons,
// syscall capture, instruction counter. Optional decimal point: SEG_DISPLAY_DP_EN.
module seg_display_ctrl #(
  parameter logic [15:0] SCAN_DIV  = 16'd50000,
  parameter logic [19:0] DB_CYCLES = 20'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        disp_btn,
  input  logic        addr_btn,
  input  logic        sys_valid,
  input  logic [31:0] sys_data,
  output logic        sys_ack,
  input  logic [31:0] pc_in,
  input  logic        cpu_step,
  output logic [11:0] dm_rd_addr,
  input  logic [31:0] dm_rd_data,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic [3:0]  dmaddr_light
);

  logic [1:0]  s1_q, s2_q, db_q;
  logic [19:0] dbc_q [2];
  logic [1:0]  press;
  logic [1:0]  mode_q;
  logic [3:0]  idx_q;
  logic        ack_q;
  logic [31:0] sysreg_q;
  logic [31:0] icnt_q;
  logic [15:0] pre_q, pre_d;
  logic [2:0]  dig_q, dig_d;
  logic [31:0] shown_q, shown_d;
  logic [7:0]  seg_q, seg_d;
  logic [7:0]  an_q, an_d;
  logic [31:0] src;
  logic        tick;
  logic        dp;
  logic [3:0]  nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    unique case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // A press fires on the cycle the debounced level flips 0->1
  always_comb begin
    press = '0;
    for (int i = 0; i < 2; i++) begin
      press[i] = s2_q[i] & ~db_q[i]
               & (dbc_q[i] == DB_CYCLES - 20'd1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      for (int i = 0; i < 2; i++) dbc_q[i] <= '0;
    end else begin
      s1_q <= {addr_btn, disp_btn};
      s2_q <= s1_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == db_q[i]) begin
          dbc_q[i] <= '0;
        end else if (dbc_q[i] == DB_CYCLES - 20'd1) begin
          dbc_q[i] <= '0;
          db_q[i]  <= s2_q[i];
        end else begin
          dbc_q[i] <= dbc_q[i] + 20'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= '0;
      idx_q    <= '0;
      ack_q    <= 1'b0;
      sysreg_q <= '0;
      icnt_q   <= '0;
    end else begin
      if (press[0]) mode_q <= mode_q + 2'd1;
      if (press[1]) idx_q <= idx_q + 4'd1;
      if (cpu_step) icnt_q <= icnt_q + 32'd1;
      if (sys_valid && !ack_q) begin
        sysreg_q <= sys_data;
        ack_q    <= 1'b1;
      end else begin
        ack_q <= 1'b0;
      end
    end
  end

  always_comb begin
    unique case (mode_q)
      2'd0: src = sysreg_q;
      2'd1: src = pc_in;
      2'd2: src = dm_rd_data;
      default: src = icnt_q;
    endcase
  end

  assign tick = (pre_q == SCAN_DIV - 16'd1);
  assign nib  = shown_q[{dig_q, 2'b00} +: 4];

`ifdef SEG_DISPLAY_DP_EN
  assign dp = (dig_q != {1'b0, mode_q});
`else
  assign dp = 1'b1;
`endif

  // Digit dig_q is driven on its tick; shown reloads as digit 7 goes out
  always_comb begin
    pre_d   = pre_q + 16'd1;
    dig_d   = dig_q;
    shown_d = shown_q;
    seg_d   = seg_q;
    an_d    = an_q;
    if (tick) begin
      pre_d = '0;
      dig_d = dig_q + 3'd1;
      an_d  = ~(8'd1 << dig_q);
      seg_d = {dp, hex7(nib)};
      if (dig_q == 3'd7) shown_d = src;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q   <= '0;
      dig_q   <= '0;
      shown_q <= '0;
      seg_q   <= 8'hFF;
      an_q    <= 8'hFF;
    end else begin
      pre_q   <= pre_d;
      dig_q   <= dig_d;
      shown_q <= shown_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign sys_ack      = ack_q;
  assign seg          = seg_q;
  assign an           = an_q;
  assign dmaddr_light = idx_q;
  assign dm_rd_addr   = {6'b0, idx_q, 2'b00};

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with a short scan period
// and a short debounce window.
module tb_seg_display_ctrl;

  localparam int SD = 4;
  localparam int DB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        disp_btn = 1'b0;
  logic        addr_btn = 1'b0;
  logic        sys_valid = 1'b0;
  logic [31:0] sys_data = '0;
  logic        sys_ack;
  logic [31:0] pc_in = 32'h0000_00C5;
  logic        cpu_step = 1'b0;
  logic [11:0] dm_rd_addr;
  logic [31:0] dm_rd_data;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic [3:0]  dmaddr_light;

  int total = 0;
  int bad = 0;
  int m = 0;

  assign dm_rd_data = {16'hBEEF, 4'h0, dm_rd_addr};

  always #5 clk = ~clk;

  seg_display_ctrl #(
    .SCAN_DIV(16'(SD)),
    .DB_CYCLES(20'(DB))
  ) dut (
    .clk(clk),
    .rst(rst),
    .disp_btn(disp_btn),
    .addr_btn(addr_btn),
    .sys_valid(sys_valid),
    .sys_data(sys_data),
    .sys_ack(sys_ack),
    .pc_in(pc_in),
    .cpu_step(cpu_step),
    .dm_rd_addr(dm_rd_addr),
    .dm_rd_data(dm_rd_data),
    .seg(seg),
    .an(an),
    .dmaddr_light(dmaddr_light)
  );

  function automatic logic dpx(input int d, input int md);
    logic on;
    on = (d == md);
`ifdef SEG_DISPLAY_DP_EN
    return ~on;
`else
    return 1'b1 | on;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_dig(input string tag, input int d,
                         input logic [6:0] hex);
    logic [7:0] want;
    bit hit;
    hit = 1'b0;
    want = ~(8'h01 << d);
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (an === want) hit = 1'b1;
    end
    chk({tag, "_an"}, {24'b0, an}, {24'b0, want});
    chk(tag, {24'b0, seg}, {24'b0, dpx(d, m), hex});
  endtask

  task automatic press(input logic d, input logic a);
    @(negedge clk);
    disp_btn = d;
    addr_btn = a;
    repeat (DB + 4) @(negedge clk);
    disp_btn = 1'b0;
    addr_btn = 1'b0;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic settle();
    repeat (8 * SD * 2 + 4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_seg", {24'b0, seg}, 32'hFF);
    chk("rst_an", {24'b0, an}, 32'hFF);
    chk("rst_ack", {31'b0, sys_ack}, 32'h0);
    chk("rst_light", {28'b0, dmaddr_light}, 32'h0);
    chk("rst_addr", {20'b0, dm_rd_addr}, 32'h0);
    rst = 1'b1;

    chk_dig("first_dig0", 0, 7'h40);

    @(negedge clk);
    sys_valid = 1'b1;
    sys_data = 32'h1234ABCD;
    @(negedge clk);
    chk("ack_hi", {31'b0, sys_ack}, 32'h1);
    sys_valid = 1'b0;
    @(negedge clk);
    chk("ack_lo", {31'b0, sys_ack}, 32'h0);
    settle();
    chk_dig("sys_d0", 0, 7'h21);
    chk_dig("sys_d7", 7, 7'h79);

    for (int i = 0; i < 6; i++) begin
      disp_btn = ~disp_btn;
      repeat (10) @(negedge clk);
    end
    disp_btn = 1'b1;
    repeat (DB + 4) @(negedge clk);
    disp_btn = 1'b0;
    repeat (DB + 4) @(negedge clk);
    m = 1;
    settle();
    chk_dig("pc_d0", 0, 7'h12);
    chk_dig("pc_d1", 1, 7'h46);

    for (int i = 1; i <= 17; i++) begin
      press(1'b0, 1'b1);
      chk($sformatf("light_%0d", i), {28'b0, dmaddr_light},
          32'(i % 16));
    end
    chk("addr_end", {20'b0, dm_rd_addr}, 32'h004);

    press(1'b1, 1'b1);
    m = 2;
    chk("both_light", {28'b0, dmaddr_light}, 32'h2);
    chk("both_addr", {20'b0, dm_rd_addr}, 32'h008);
    settle();
    chk_dig("dm_d0", 0, 7'h00);
    chk_dig("dm_d2", 2, 7'h40);
    chk_dig("dm_d7", 7, 7'h03);

    press(1'b1, 1'b0);
    m = 3;
    repeat (3) begin
      @(negedge clk);
      cpu_step = 1'b1;
      @(negedge clk);
      cpu_step = 1'b0;
    end
    settle();
    chk_dig("icnt_d0", 0, 7'h30);
    chk_dig("icnt_d3", 3, 7'h40);

    @(negedge clk);
    force dut.icnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.icnt_q;
    @(negedge clk);
    cpu_step = 1'b1;
    @(negedge clk);
    cpu_step = 1'b0;
    settle();
    chk_dig("wrap_d0", 0, 7'h40);
    chk_dig("wrap_d4", 4, 7'h40);
    chk_dig("wrap_d7", 7, 7'h40);

    press(1'b1, 1'b0);
    m = 0;
    settle();
    chk_dig("m0_d0", 0, 7'h21);

    @(negedge clk);
    sys_valid = 1'b1;
    sys_data = 32'h5555_5555;
    @(negedge clk);
    chk("rack_hi", {31'b0, sys_ack}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rack_ack", {31'b0, sys_ack}, 32'h0);
    chk("rack_seg", {24'b0, seg}, 32'hFF);
    chk("rack_an", {24'b0, an}, 32'hFF);
    chk("rack_light", {28'b0, dmaddr_light}, 32'h0);
    sys_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_dig("post_d0", 0, 7'h40);
    settle();
    chk_dig("post_s0", 0, 7'h40);
    chk_dig("post_s7", 7, 7'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16'd50000, clk cycles per digit-scan tick.
REQ-002 SHALL have parameter DB_CYCLES, default 20'd1000000, clk cycles a button must be stable before it is accepted.
REQ-003 SHALL have port clk  input  1  single system clock; all state is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port disp_btn  input  1  raw display-mode button, asynchronous to clk.
REQ-006 SHALL have port addr_btn  input  1  raw memory-address button, asynchronous to clk.
REQ-007 SHALL have port sys_valid  input  1  CPU syscall display request.
REQ-008 SHALL have port sys_data  input  32  syscall value ($a0).
REQ-009 SHALL have port sys_ack  output  1  one-cycle acknowledge that sys_data was captured.
REQ-010 SHALL have port pc_in  input  32  current CPU PC.
REQ-011 SHALL have port cpu_step  input  1  one-cycle pulse per retired instruction.
REQ-012 SHALL have port dm_rd_addr  output  12  data-memory byte address to read.
REQ-013 SHALL have port dm_rd_data  input  32  data-memory word at dm_rd_addr (combinational).
REQ-014 SHALL have port seg  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
REQ-015 SHALL have port an  output  8  digit enables, active-low, an[i] is digit i.
REQ-016 SHALL have port dmaddr_light  output  4  selected memory word index.

Function
REQ-017 SHALL pass each button through a 2-FF synchronizer, then a debouncer whose stable value changes only after the synchronized input differs from it for DB_CYCLES consecutive cycles.
REQ-018 SHALL generate a one-cycle press pulse on each 0->1 change of a debounced button.
REQ-019 SHALL keep a 2-bit mode register, advancing 0->1->2->3->0 on each disp press.
REQ-020 SHALL keep a 4-bit word index, incrementing on each addr press and wrapping 15->0; dmaddr_light = index, dm_rd_addr = {6'b0, index, 2'b00}.
REQ-021 SHALL, when both presses occur in the same cycle, apply both independently.
REQ-022 SHALL capture sys_data into a 32-bit syscall register and assert sys_ack for exactly one cycle in the cycle after sys_valid is sampled high with sys_ack low; valid held high therefore gets ack every other cycle; the initiator SHALL drop sys_valid after ack.
REQ-023 SHALL keep a 32-bit instruction counter incrementing on cpu_step, wrapping 32'hFFFFFFFF->0.
REQ-024 SHALL select the source word by mode: 0 syscall register, 1 pc_in, 2 dm_rd_data, 3 instruction counter.
REQ-025 SHALL run a scan prescaler producing a tick every SCAN_DIV cycles and a 3-bit digit index incremented per tick, wrapping 7->0.
REQ-026 SHALL latch the source word into a shown register on the tick that moves the index 7->0, so one scan frame never mixes two values.
REQ-027 SHALL drive, one cycle after each tick, an = ~(1<<index) and seg[6:0] = hex decode of shown[4*index+3:4*index].
REQ-028 SHALL decode hex active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.

Reset
REQ-029 SHALL, while rst is low, hold seg=8'hFF, an=8'hFF, sys_ack=0, dmaddr_light=0, dm_rd_addr=0, and clear mode, index, syscall register, instruction counter, shown register, prescaler and debouncers.
REQ-030 SHALL, on reset mid-press or mid-handshake, discard the press and any pending capture; first digit drive after release is digit 0 on the first tick.

Configuration
REQ-031 SHALL, with SEG_DISPLAY_DP_EN defined, drive seg[7]=0 on the digit whose index equals mode, else 1; without it, seg[7] is always 1.

Verification
REQ-032 SHALL test: sys_valid=1, sys_data=32'h1234ABCD for one cycle -> sys_ack pulse next cycle; after next frame latch, digit 0 seg[6:0]=7'h21, digit 7 seg[6:0]=7'h79.
REQ-033 SHALL test: disp_btn bounce 0/1 every 10 cycles, then held 1 for DB_CYCLES+4 -> mode advances exactly once (0->1), display shows pc_in.
REQ-034 SHALL test: 17 clean addr presses -> dmaddr_light 1,2,...,15,0,1 and dm_rd_addr=12'h004 at end.
REQ-035 SHALL test: 4 disp presses from reset -> mode returns to 0; with SEG_DISPLAY_DP_EN, mode 2 -> seg[7]=0 only when an=8'hFB.
REQ-036 SHALL test: instruction counter preset via 32'hFFFFFFFF cpu_step pulses (or forced) plus one pulse -> mode 3 shows all digits 7'h40.
REQ-037 SHALL test: rst low during sys_ack cycle -> sys_ack=0, seg=8'hFF, an=8'hFF immediately, syscall register 0 after release.
